// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller for the 5-stage core: forwarding, load-use,
// control flushes, cache-miss freezes, multi-cycle execute and stall counting.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  CPU_CLK,
    input  logic                  CPU_RST_N,
    input  logic                  ICacheMiss,
    input  logic                  DCacheMiss,
    input  logic                  BranchE,
    input  logic                  JalrE,
    input  logic                  JalD,
    input  logic                  MulStartE,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [1:0]            RegReadD,
    input  logic [1:0]            RegReadE,
    input  logic                  MemToRegE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ClrCnt,
    output logic                  StallF,
    output logic                  FlushF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  StallE,
    output logic                  FlushE,
    output logic                  StallM,
    output logic                  FlushM,
    output logic                  StallW,
    output logic                  FlushW,
    output logic [1:0]            Forward1E,
    output logic [1:0]            Forward2E,
    output logic                  McBusy,
    output logic [CNT_W-1:0]      StallCycles
);

    localparam int MCW = (MC_LAT > 4) ? $clog2(MC_LAT - 2) : 1;
    localparam logic [MCW-1:0] MC_INIT = MCW'(MC_LAT - 3);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_t;

    mc_state_t        state;
    mc_state_t        state_nx;
    logic [MCW-1:0]   cnt;
    logic [MCW-1:0]   cnt_nx;
    logic [CNT_W-1:0] stall_cnt;

    logic m_hit1;
    logic w_hit1;
    logic m_hit2;
    logic w_hit2;
    logic lu;
    logic mc;

    logic base_stall_f;
    logic base_stall_d;
    logic base_stall_e;
    logic base_stall_m;
    logic base_flush_d;
    logic base_flush_e;
    logic base_flush_m;
    logic base_flush_w;
    logic redirect_e;
    logic redirect_d;

    // Forwarding: M result is younger than W, so it wins.
    assign m_hit1 = RegReadE[1] & RegWriteM & (RdM != '0) & (Rs1E == RdM);
    assign w_hit1 = RegReadE[1] & RegWriteW & (RdW != '0) & (Rs1E == RdW);
    assign m_hit2 = RegReadE[0] & RegWriteM & (RdM != '0) & (Rs2E == RdM);
    assign w_hit2 = RegReadE[0] & RegWriteW & (RdW != '0) & (Rs2E == RdW);

    always_comb begin
        Forward1E = 2'b00;
        Forward2E = 2'b00;
        if (m_hit1) begin
            Forward1E = 2'b10;
        end else if (w_hit1) begin
            Forward1E = 2'b01;
        end
        if (m_hit2) begin
            Forward2E = 2'b10;
        end else if (w_hit2) begin
            Forward2E = 2'b01;
        end
    end

    assign lu = MemToRegE & (RdE != '0)
              & ((RegReadD[1] & (Rs1D == RdE))
               | (RegReadD[0] & (Rs2D == RdE)));

    assign mc = ((state == IDLE) & MulStartE) | (state == BUSY);

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A D-cache miss freezes the whole multi-cycle sequencer.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!DCacheMiss) begin
            case (state)
                IDLE: begin
                    if (MulStartE) begin
                        state_nx = BUSY;
                        cnt_nx   = MC_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt - MCW'(1);
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign McBusy = (state != IDLE);

    always_comb begin
        base_stall_f = 1'b0;
        base_stall_d = 1'b0;
        base_stall_e = 1'b0;
        base_stall_m = 1'b0;
        base_flush_d = 1'b0;
        base_flush_e = 1'b0;
        base_flush_m = 1'b0;
        base_flush_w = 1'b0;
        if (DCacheMiss) begin
            base_stall_f = 1'b1;
            base_stall_d = 1'b1;
            base_stall_e = 1'b1;
            base_stall_m = 1'b1;
            base_flush_w = 1'b1;
        end else if (mc) begin
            base_stall_f = 1'b1;
            base_stall_d = 1'b1;
            base_stall_e = 1'b1;
            base_flush_m = 1'b1;
        end else if (ICacheMiss) begin
            base_stall_f = 1'b1;
            base_flush_d = 1'b1;
        end else if (lu) begin
            base_stall_f = 1'b1;
            base_stall_d = 1'b1;
            base_flush_e = 1'b1;
        end
    end

    // A held E stage defers its redirect until E is free to move.
    assign redirect_e = (BranchE | JalrE) & ~base_stall_e;
    assign redirect_d = JalD & ~base_stall_d & ~redirect_e;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
        FlushW = 1'b1;
        if (CPU_RST_N) begin
            StallF = base_stall_f & ~redirect_e & ~redirect_d;
            StallD = base_stall_d & ~redirect_e;
            StallE = base_stall_e;
            StallM = base_stall_m;
            FlushF = redirect_e | redirect_d;
            FlushD = base_flush_d | redirect_e;
            FlushE = base_flush_e | redirect_e;
            FlushM = base_flush_m;
            FlushW = base_flush_w;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            stall_cnt <= '0;
        end else if (ClrCnt) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with a narrow stall counter so that
// saturation is reachable in a short run.
module tb_hazard_unit_mc;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          icm, dcm, br, jalr, jald, mul;
    logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    rrd, rre;
    logic          m2r, rwm, rww, clr;
    logic          sf, ff, sd, fd, se, fe, sm, fm, sw, fw;
    logic [1:0]    f1, f2;
    logic          busy;
    logic [CW-1:0] cyc;

    logic [4:0] stalls;
    logic [4:0] flushes;
    assign stalls  = {sf, sd, se, sm, sw};
    assign flushes = {ff, fd, fe, fm, fw};

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit_mc #(
        .REG_ADDR_W(RW),
        .MC_LAT(4),
        .CNT_W(CW)
    ) dut (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .ICacheMiss(icm), .DCacheMiss(dcm),
        .BranchE(br), .JalrE(jalr), .JalD(jald), .MulStartE(mul),
        .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
        .RdE(rde), .RdM(rdm), .RdW(rdw),
        .RegReadD(rrd), .RegReadE(rre),
        .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
        .ClrCnt(clr),
        .StallF(sf), .FlushF(ff), .StallD(sd), .FlushD(fd),
        .StallE(se), .FlushE(fe), .StallM(sm), .FlushM(fm),
        .StallW(sw), .FlushW(fw),
        .Forward1E(f1), .Forward2E(f2),
        .McBusy(busy), .StallCycles(cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        icm = 0; dcm = 0; br = 0; jalr = 0; jald = 0; mul = 0;
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0;
        rde = 0; rdm = 0; rdw = 0;
        rrd = 0; rre = 0; m2r = 0; rwm = 0; rww = 0; clr = 0;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #3;
        chk("rst_flush", 32'(flushes), 32'h1f);
        chk("rst_stall", 32'(stalls), 32'h00);
        chk("rst_cnt", 32'(cyc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // Forwarding
        rre = 2'b10; rs1e = 5; rdm = 5; rwm = 1; rdw = 7; rww = 1;
        #1;
        chk("fwd_m", 32'(f1), 32'h2);
        chk("fwd_m_f2", 32'(f2), 32'h0);
        chk("idle_stall", 32'(stalls), 32'h00);
        chk("idle_flush", 32'(flushes), 32'h00);
        rdm = 7; rdw = 5;
        #1;
        chk("fwd_w", 32'(f1), 32'h1);
        rs1e = 0; rdm = 0; rdw = 0;
        #1;
        chk("fwd_x0", 32'(f1), 32'h0);
        rs1e = 5; rdm = 5; rdw = 5;
        #1;
        chk("fwd_mw", 32'(f1), 32'h2);
        rre = 2'b01; rs2e = 9; rdm = 4; rdw = 9;
        #1;
        chk("fwd2_w", 32'(f2), 32'h1);
        chk("fwd2_f1", 32'(f1), 32'h0);
        idle_in();

        // Load-use
        m2r = 1; rde = 3; rrd = 2'b01; rs2d = 3; rs1d = 0;
        #1;
        chk("lu_stall", 32'(stalls), 32'h18);
        chk("lu_flush", 32'(flushes), 32'h04);
        tick();
        idle_in();
        #1;
        chk("lu_cnt", 32'(cyc), 32'h1);
        m2r = 1; rde = 0; rrd = 2'b01; rs2d = 0;
        #1;
        chk("lu_x0", 32'(stalls), 32'h00);
        tick();
        idle_in();
        clr = 1;
        tick();
        clr = 0;
        #1;
        chk("clr_cnt", 32'(cyc), 32'h0);

        // Multi-cycle op, held high through DONE
        mul = 1;
        #1;
        chk("mc1_stall", 32'(stalls), 32'h1c);
        chk("mc1_flush", 32'(flushes), 32'h02);
        chk("mc1_busy", 32'(busy), 32'h0);
        tick();
        chk("mc2_stall", 32'(stalls), 32'h1c);
        chk("mc2_busy", 32'(busy), 32'h1);
        tick();
        chk("mc3_stall", 32'(stalls), 32'h1c);
        chk("mc3_busy", 32'(busy), 32'h1);
        tick();
        chk("mc4_stall", 32'(stalls), 32'h00);
        chk("mc4_busy", 32'(busy), 32'h1);
        tick();
        mul = 0;
        #1;
        chk("mc5_busy", 32'(busy), 32'h0);
        chk("mc5_stall", 32'(stalls), 32'h00);
        chk("mc_cnt", 32'(cyc), 32'h3);
        clr = 1;
        tick();
        clr = 0;

        // D-cache miss while BUSY with cnt = 1
        mul = 1;
        tick();
        dcm = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("dm_stall", 32'(stalls), 32'h1e);
            chk("dm_flush", 32'(flushes), 32'h01);
            chk("dm_busy", 32'(busy), 32'h1);
            tick();
        end
        dcm = 0;
        #1;
        chk("dm_res1", 32'(stalls), 32'h1c);
        tick();
        chk("dm_res2", 32'(stalls), 32'h1c);
        tick();
        chk("dm_done", 32'(stalls), 32'h00);
        chk("dm_done_busy", 32'(busy), 32'h1);
        tick();
        mul = 0;
        #1;
        chk("dm_idle", 32'(busy), 32'h0);
        chk("dm_cnt", 32'(cyc), 32'h8);

        // Branch deferred behind D-cache miss, then JalD
        dcm = 1; br = 1;
        #1;
        chk("br_held_flush", 32'(flushes), 32'h01);
        chk("br_held_stall", 32'(stalls), 32'h1e);
        tick();
        dcm = 0;
        #1;
        chk("br_flush", 32'(flushes), 32'h1c);
        chk("br_stall", 32'(stalls), 32'h00);
        tick();
        br = 0; jald = 1;
        #1;
        chk("jald_flush", 32'(flushes), 32'h10);
        chk("jald_stall", 32'(stalls), 32'h00);
        m2r = 1; rde = 6; rrd = 2'b10; rs1d = 6;
        #1;
        chk("jald_lu_flush", 32'(flushes), 32'h04);
        chk("jald_lu_stall", 32'(stalls), 32'h18);
        jald = 0; jalr = 1;
        #1;
        chk("jalr_lu_flush", 32'(flushes), 32'h1c);
        chk("jalr_lu_stall", 32'(stalls), 32'h00);
        tick();
        idle_in();

        // Saturation and clear priority
        icm = 1;
        #1;
        chk("ic_stall", 32'(stalls), 32'h10);
        chk("ic_flush", 32'(flushes), 32'h08);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(cyc), 32'hf);
        clr = 1;
        tick();
        clr = 0; icm = 0;
        #1;
        chk("sat_clr", 32'(cyc), 32'h0);

        // Async reset in the middle of BUSY
        mul = 1;
        tick();
        mul = 0;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_cnt", 32'(cyc), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flushes), 32'h1f);
        chk("arst_stall", 32'(stalls), 32'h00);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_cnt", 32'(cyc), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_flush", 32'(flushes), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
